// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared definitions for the sequential BCD-to-signed-binary converter.
package bcd_to_bin_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam int unsigned BCD_MAX_DIGIT = 9;

  // Saturation limits of a (width+1)-bit two's-complement operand:
  // largest positive value and magnitude of the most negative value.
  typedef struct packed {
    logic [31:0] pos_max;
    logic [31:0] neg_mag;
  } sat_lim_t;

  function automatic sat_lim_t sat_limits(input int unsigned width);
    sat_lim_t lim;
    lim.neg_mag = 32'd1 << width;
    lim.pos_max = lim.neg_mag - 32'd1;
    return lim;
  endfunction

endpackage

// File: rtl/bcd_to_bin_seq_digit_check.sv
// Flags a single BCD nibble that is not a legal decimal digit.
module bcd_digit_check
  import bcd_to_bin_seq_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic       bad_o
);

  assign bad_o = (nibble_i > 4'(BCD_MAX_DIGIT));

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Iterative BCD-to-signed-binary converter: Horner accumulation, one digit
// per clock, with start/busy/done handshake and saturated signed output.
module bcd_to_bin_seq
  import bcd_to_bin_seq_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [4*DIGITS-1:0]     bcd_in,
  input  logic                    neg,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH:0]   value,
  output logic                    invalid,
  output logic                    overflow
);

  localparam int       ACC_W = 4 * DIGITS;
  localparam int       CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam sat_lim_t LIM   = sat_limits(WIDTH);

  state_e                state_q, state_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [ACC_W-1:0]      bcd_q, bcd_d;
  logic                  neg_q, neg_d;
  logic                  inv_q, inv_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic signed [WIDTH:0] value_q, value_d;
  logic                  invalid_q, invalid_d;
  logic                  overflow_q, overflow_d;

  logic [DIGITS-1:0]     nib_bad;
  logic [3:0]            cur_nib;
  logic [ACC_W-1:0]      acc_mul10;
  logic [31:0]           acc_ext;
  logic signed [WIDTH:0] res_value;
  logic                  res_invalid;
  logic                  res_overflow;

  for (genvar g = 0; g < DIGITS; g++) begin : g_chk
    bcd_digit_check u_chk (
      .nibble_i (bcd_in[4*g +: 4]),
      .bad_o    (nib_bad[g])
    );
  end

  // Digit currently consumed, MSD first; acc*10 done as (acc<<3)+(acc<<1).
  assign cur_nib   = bcd_q[{cnt_q, 2'b00} +: 4];
  assign acc_mul10 = (acc_q << 3) + (acc_q << 1) + ACC_W'(cur_nib);
  assign acc_ext   = 32'(acc_q);

  // Final result from the accumulated magnitude, rules in priority order.
  always_comb begin
    res_value    = '0;
    res_invalid  = 1'b0;
    res_overflow = 1'b0;
    if (inv_q) begin
      res_invalid = 1'b1;
    end else if (neg_q && (acc_ext == 32'd0)) begin
      res_value = '0;
    end else if (!neg_q && (acc_ext > LIM.pos_max)) begin
      res_value    = (WIDTH+1)'(LIM.pos_max);
      res_overflow = 1'b1;
    end else if (neg_q && (acc_ext > LIM.neg_mag)) begin
      res_value    = (WIDTH+1)'(32'd0 - LIM.neg_mag);
      res_overflow = 1'b1;
    end else if (neg_q) begin
      res_value = (WIDTH+1)'(32'd0 - acc_ext);
    end else begin
      res_value = (WIDTH+1)'(acc_ext);
    end
  end

  // Next-state and datapath control; done defaults low so it pulses.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    bcd_d      = bcd_q;
    neg_d      = neg_q;
    inv_d      = inv_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    value_d    = value_q;
    invalid_d  = invalid_q;
    overflow_d = overflow_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          bcd_d   = bcd_in;
          neg_d   = neg;
          inv_d   = |nib_bad;
          acc_d   = '0;
          cnt_d   = CNT_W'(DIGITS - 1);
          busy_d  = 1'b1;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = acc_mul10;
        if (cnt_q == '0) begin
          state_d = FIN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIN: begin
        value_d    = res_value;
        invalid_d  = res_invalid;
        overflow_d = res_overflow;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and register update; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      bcd_q      <= '0;
      neg_q      <= 1'b0;
      inv_q      <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      value_q    <= '0;
      invalid_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      bcd_q      <= bcd_d;
      neg_q      <= neg_d;
      inv_q      <= inv_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      value_q    <= value_d;
      invalid_q  <= invalid_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign value    = value_q;
  assign invalid  = invalid_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Bench for bcd_to_bin_seq (WIDTH=4, DIGITS=2): directed and random
// conversions checked against a decimal reference model.
module tb_bcd_to_bin_seq;

  localparam int WIDTH  = 4;
  localparam int DIGITS = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  start = 1'b0;
  logic [4*DIGITS-1:0]   bcd_in = '0;
  logic                  neg = 1'b0;
  logic                  busy;
  logic                  done;
  logic signed [WIDTH:0] value;
  logic                  invalid;
  logic                  overflow;

  int total = 0;
  int bad   = 0;

  bcd_to_bin_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bcd_in   (bcd_in),
    .neg      (neg),
    .busy     (busy),
    .done     (done),
    .value    (value),
    .invalid  (invalid),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: decimal value of the digits, then signed saturation rules.
  function automatic void model(input logic [4*DIGITS-1:0] b, input logic n,
                                output logic signed [WIDTH:0] v,
                                output logic inv, output logic ovf);
    int   mag;
    int   d;
    int   maxp;
    int   minm;
    logic [4*DIGITS-1:0] bb;
    bb   = b;
    mag  = 0;
    inv  = 1'b0;
    ovf  = 1'b0;
    maxp = (1 << WIDTH) - 1;
    minm = 1 << WIDTH;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = int'(bb[4*i +: 4]);
      if (d > 9) inv = 1'b1;
      mag = mag * 10 + d;
    end
    if (inv)                     v = '0;
    else if (n && mag == 0)      v = '0;
    else if (!n && mag > maxp) begin v = (WIDTH+1)'(maxp); ovf = 1'b1; end
    else if (n && mag > minm)  begin v = (WIDTH+1)'(-minm); ovf = 1'b1; end
    else                         v = n ? (WIDTH+1)'(-mag) : (WIDTH+1)'(mag);
  endfunction

  // One conversion: pulse start, wait (bounded) for done, check result.
  task automatic convert(input string tag, input logic [4*DIGITS-1:0] b, input logic n);
    logic signed [WIDTH:0] ev;
    logic ei, eo;
    int lat;
    int busy_cnt;
    model(b, n, ev, ei, eo);
    @(negedge clk);
    bcd_in = b; neg = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bcd_in = ~b; neg = ~n;
    lat = 1;
    busy_cnt = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_lat"}, 32'(lat - 1), 32'(DIGITS + 1));
    check({tag, "_busycnt"}, 32'(busy_cnt), 32'(DIGITS + 1));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_value"}, 32'(value), 32'(ev));
    check({tag, "_invalid"}, 32'(invalid), 32'(ei));
    check({tag, "_overflow"}, 32'(overflow), 32'(eo));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_value_held"}, 32'(value), 32'(ev));
  endtask

  initial begin
    int dones;
    int lat;
    logic [4*DIGITS-1:0] rb;
    logic rn;

    // Reset held with start high: nothing may be accepted.
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_value", 32'(value), 32'd0);
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_idle_busy", 32'(busy), 32'd0);

    convert("pos15", 8'h15, 1'b0);
    convert("neg16", 8'h16, 1'b1);
    convert("negzero", 8'h00, 1'b1);
    convert("sat_pos", 8'h16, 1'b0);
    convert("sat_neg", 8'h99, 1'b1);
    convert("inv1A", 8'h1A, 1'b0);
    convert("after_inv", 8'h07, 1'b0);
    convert("neg9", 8'h09, 1'b1);

    // Asynchronous reset pulsed mid-cycle clears held outputs at once.
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_value", 32'(value), 32'd0);
    check("async_invalid", 32'(invalid), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // start re-asserted while busy is ignored: exactly one done.
    @(negedge clk);
    bcd_in = 8'h12; neg = 1'b0; start = 1'b1;
    @(negedge clk);
    bcd_in = 8'h03;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        dones++;
        check("busy_ign_value", 32'(value), 32'd12);
      end
      @(negedge clk);
    end
    check("busy_ign_dones", 32'(dones), 32'd1);

    // start held through done: second conversion accepted back-to-back.
    bcd_in = 8'h11; neg = 1'b1; start = 1'b1;
    @(negedge clk);
    lat = 1;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    check("b2b_first_done", 32'(done), 32'd1);
    check("b2b_first_value", 32'(value), 32'(5'sd0 - 5'sd11));
    bcd_in = 8'h07; neg = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy_again", 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    check("b2b_second_done", 32'(done), 32'd1);
    check("b2b_second_value", 32'(value), 32'd7);

    // Reset during ACC aborts: no done, held value cleared.
    convert("pre_abort", 8'h13, 1'b0);
    @(negedge clk);
    bcd_in = 8'h05; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_value", 32'(value), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(dones), 32'd0);

    // Random conversions, including occasional illegal nibbles.
    for (int i = 0; i < 40; i++) begin
      rb = 8'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        rb[7:4] = 4'($urandom_range(0, 9));
        rb[3:0] = 4'($urandom_range(0, 9));
      end
      rn = 1'($urandom);
      convert("rand", rb, rn);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
